// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction formats, base opcodes, nop word
// and the signed-range helper used by the field packer.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned FMT_W     = 3;
   localparam int unsigned OPCODE_W  = 7;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned FUNCT3_W  = 3;
   localparam int unsigned FUNCT7_W  = 7;
   localparam int unsigned ERRCNT_W  = 8;

   typedef enum logic [FMT_W-1:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_S  = 3'd2,
      FMT_SB = 3'd3,
      FMT_U  = 3'd4,
      FMT_UJ = 3'd5
   } fmt_e;

   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // Registered payload of the output stage.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] addr;
      logic            err;
   } out_word_t;

   // True when imm is a sign extension of its low (msb+1) bits.
   function automatic logic fits_signed(input logic [XLEN-1:0] imm, input int unsigned msb);
      logic [XLEN-1:0] upper;
      upper = XLEN'($signed(imm) >>> msb);
      return (upper == '0) || (upper == '1);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: places fields and the swizzled immediate per format and
// flags immediates that do not fit the format's encodable range.
module instr_pack
   import riscv_pkg::*;
(
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic [31:0] instr_c,
   output logic        err_c
);

   logic imm_even;
   logic fit12;
   logic fit13;
   logic fit21;
   logic low12_zero;

   assign imm_even   = ~in_imm[0];
   assign fit12      = fits_signed(in_imm, 32'd11);
   assign fit13      = fits_signed(in_imm, 32'd12);
   assign fit21      = fits_signed(in_imm, 32'd20);
   assign low12_zero = (in_imm[11:0] == 12'h000);

   // Out-of-range words are still packed from the truncated immediate bits.
   always_comb begin
      instr_c = NOP_INSTR;
      err_c   = 1'b1;
      case (in_fmt)
         FMT_R: begin
            instr_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            err_c   = 1'b0;
         end
         FMT_I: begin
            instr_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            err_c   = ~fit12;
         end
         FMT_S: begin
            instr_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            err_c   = ~fit12;
         end
         FMT_SB: begin
            instr_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
            err_c   = ~(fit13 & imm_even);
         end
         FMT_U: begin
            instr_c = {in_imm[31:12], in_rd, in_opcode};
            err_c   = ~low12_zero;
         end
         FMT_UJ: begin
            instr_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            err_c   = ~(fit21 & imm_even);
         end
         default: begin
            instr_c = NOP_INSTR;
            err_c   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: valid/ready input, one registered output stage, running
// word address counter and saturating count of emitted out-of-range words.
module instr_encoder
   import riscv_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        out_err,
   output logic [7:0]  err_count
);

   localparam logic [31:0] STEP = 32'(ADDR_STEP);

   logic [31:0] pack_instr_c;
   logic        pack_err_c;
   logic        in_acc_c;
   logic        out_acc_c;

   out_word_t   word_q,  word_d;
   logic        valid_q, valid_d;
   logic [31:0] cnt_q,   cnt_d;
   logic [7:0]  errc_q,  errc_d;

   instr_pack u_pack (
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .instr_c   (pack_instr_c),
      .err_c     (pack_err_c)
   );

   // The stage accepts whenever it is empty or draining this cycle, so no bubble.
   assign in_ready  = (~valid_q | out_ready) & ~flush;
   assign in_acc_c  = in_valid & in_ready;
   assign out_acc_c = valid_q & out_ready;

   // Next-state: flush dominates; otherwise load, drain and count errors.
   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      errc_d  = errc_q;
      if (flush) begin
         valid_d = 1'b0;
         cnt_d   = BASE_ADDR;
      end else begin
         if (out_acc_c && word_q.err && (errc_q != 8'hFF)) begin
            errc_d = errc_q + 8'd1;
         end
         if (in_acc_c) begin
            valid_d      = 1'b1;
            word_d.instr = pack_instr_c;
            word_d.err   = pack_err_c;
            word_d.addr  = cnt_q;
            cnt_d        = cnt_q + STEP;
         end else if (out_acc_c) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         word_q.instr <= '0;
         word_q.addr  <= BASE_ADDR;
         word_q.err   <= 1'b0;
         valid_q      <= 1'b0;
         cnt_q        <= BASE_ADDR;
         errc_q       <= '0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         errc_q  <= errc_d;
      end
   end

   assign out_valid = valid_q;
   assign out_instr = word_q.instr;
   assign out_addr  = word_q.addr;
   assign out_err   = word_q.err;
   assign err_count = errc_q;

endmodule
